// File: rtl/pipe_addsub.sv
// rtl/pipe_addsub.sv - pipelined chunked add/subtract unit with valid/ready flow control
module pipe_addsub #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             sub,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             cout,
  output logic             overflow,
  output logic             zero
);

  localparam int CHUNK = WIDTH / STAGES;
  localparam int LAST  = STAGES - 1;

  // Stage k registers hold the operands (skew), the partial sum with chunks
  // 0..k filled in (deskew), the carry out of chunk k and the beat's valid bit.
  logic [WIDTH-1:0] st_a [STAGES];
  logic [WIDTH-1:0] st_b [STAGES];
  logic [WIDTH-1:0] st_s [STAGES];
  logic             st_c [STAGES];
  logic             st_v [STAGES];

  logic [WIDTH-1:0] nx_a [STAGES];
  logic [WIDTH-1:0] nx_b [STAGES];
  logic [WIDTH-1:0] nx_s [STAGES];
  logic             nx_c [STAGES];
  logic             nx_v [STAGES];

  logic             nx_ovf;
  logic             nx_zero;
  logic             ovf_q;
  logic             zero_q;
  logic             advance;

  // The whole pipe moves together; a held output freezes every stage, bubbles included.
  assign advance  = !st_v[LAST] || out_ready;
  assign in_ready = advance;

  // Per-stage chunk adders: stage 0 works on the live inputs, stage k on stage k-1's registers.
  always_comb begin
    logic [CHUNK:0] sum;
    sum = '0;
    for (int k = 0; k < STAGES; k++) begin
      nx_a[k] = '0;
      nx_b[k] = '0;
      nx_s[k] = '0;
      nx_c[k] = 1'b0;
      nx_v[k] = 1'b0;
    end

    // Subtract is A + ~B + !cin, so the borrow-in flips into a carry-in.
    nx_a[0] = A;
    nx_b[0] = sub ? ~B : B;
    sum = {1'b0, A[CHUNK-1:0]} + {1'b0, nx_b[0][CHUNK-1:0]} + {{CHUNK{1'b0}}, cin ^ sub};
    nx_s[0][CHUNK-1:0] = sum[CHUNK-1:0];
    nx_c[0] = sum[CHUNK];
    nx_v[0] = in_valid;

    for (int k = 1; k < STAGES; k++) begin
      nx_a[k] = st_a[k-1];
      nx_b[k] = st_b[k-1];
      nx_s[k] = st_s[k-1];
      sum = {1'b0, st_a[k-1][k*CHUNK +: CHUNK]} + {1'b0, st_b[k-1][k*CHUNK +: CHUNK]}
          + {{CHUNK{1'b0}}, st_c[k-1]};
      nx_s[k][k*CHUNK +: CHUNK] = sum[CHUNK-1:0];
      nx_c[k] = sum[CHUNK];
      nx_v[k] = st_v[k-1];
    end
  end

  // Flags are derived from the fully assembled result entering the last register.
  always_comb begin
    nx_zero = (nx_s[LAST] == '0);
    nx_ovf  = (nx_a[LAST][WIDTH-1] == nx_b[LAST][WIDTH-1]) &&
              (nx_s[LAST][WIDTH-1] != nx_a[LAST][WIDTH-1]);
  end

  // Stage registers: cleared on reset, shifted together whenever the pipe advances.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        st_a[k] <= '0;
        st_b[k] <= '0;
        st_s[k] <= '0;
        st_c[k] <= 1'b0;
        st_v[k] <= 1'b0;
      end
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else if (advance) begin
      for (int k = 0; k < STAGES; k++) begin
        st_a[k] <= nx_a[k];
        st_b[k] <= nx_b[k];
        st_s[k] <= nx_s[k];
        st_c[k] <= nx_c[k];
        st_v[k] <= nx_v[k];
      end
      ovf_q  <= nx_ovf;
      zero_q <= nx_zero;
    end
  end

  assign S         = st_s[LAST];
  assign cout      = st_c[LAST];
  assign out_valid = st_v[LAST];
  assign overflow  = ovf_q;
  assign zero      = zero_q;

endmodule

// File: doc/pipe_addsub.md
# pipe_addsub

Parametrised, pipelined add/subtract unit: a WIDTH-bit adder split into STAGES carry-registered chunks, with carry-in, subtract mode, status flags and a valid/ready stream interface. It is the ALU's arithmetic datapath for wide or high-frequency builds, where a single-cycle ripple chain is too slow. It accepts one operation per cycle and returns results in order after a fixed latency of STAGES cycles.

## Interface
- WIDTH, 32: operand and result width. Must be ≥ 2.
- STAGES, 4: number of pipeline stages. Must be ≥ 1, and WIDTH % STAGES == 0. CHUNK = WIDTH/STAGES bits are added per stage.
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  operand beat present.
- in_ready  out  1  unit can accept a beat this cycle.
- A  in  WIDTH  operand A.
- B  in  WIDTH  operand B.
- sub  in  1  0 = add, 1 = subtract.
- cin  in  1  carry-in (add) or borrow-in (subtract).
- out_valid  out  1  result beat present.
- out_ready  in  1  downstream accepts the result.
- S  out  WIDTH  result.
- cout  out  1  carry out of the MSB.
- overflow  out  1  signed (two's complement) overflow.
- zero  out  1  S == 0.

## Operation
- Arithmetic:
  - Add: S = A + B + cin.
  - Subtract: S = A + ~B + !cin, i.e. A − B − cin.
  - All arithmetic is modulo 2^WIDTH.
- cout is the raw carry out of bit WIDTH−1. In subtract mode, cout = 1 means no borrow.
- overflow = (A'[MSB] == B'[MSB]) && (S[MSB] != A'[MSB]), where A' = A and B' is the effective addend (B for add, ~B for subtract).
- zero = (S == 0), evaluated over the full result.
- Stage structure:
  - Stage k (0..STAGES−1) adds chunk k of A and B' plus the carry registered from stage k−1. Stage 0 uses the mode-adjusted cin.
  - Higher operand chunks travel through skew registers until their stage.
  - Completed low chunks travel through deskew registers, so all S bits emerge aligned.
- Flow control:
  - advance = !out_valid || out_ready.
  - in_ready = advance.
  - A beat is accepted when in_valid && in_ready.
  - When advance = 0, every stage register holds, including bubbles. Bubbles are not collapsed.
  - Each stage has a valid bit that shifts along with its data on advance.
- Output stability: when out_valid = 1 and out_ready = 0, S, cout, overflow and zero hold stable until the beat is accepted.
- Ordering: results leave in acceptance order, with no loss or duplication.
- Reset (rst = 1 at an edge):
  - All stage valid bits clear, so in-flight operations are discarded.
  - out_valid = 0; S = 0, cout = 0, overflow = 0, zero = 0.
  - in_ready is 1 from the first cycle after reset (out_valid = 0).
  - Inputs presented during a reset cycle are not accepted.
- Degenerate cases:
  - STAGES = 1: one registered full-width add.
  - STAGES = WIDTH: one bit per stage, with a carry register between every bit.

## Timing
- Latency: a beat accepted at edge N appears with out_valid = 1 after edge N+STAGES−1, i.e. at edge N+STAGES−1 for STAGES = 1. Equivalently, the result is visible STAGES cycles after the cycle in which it was accepted.
- Throughput: one beat per cycle while out_ready = 1.
- Stall: out_ready low for M cycles while out_valid = 1 delays every in-flight beat by exactly M cycles. in_ready is low during those cycles.
- Simultaneous accept and drain: an input beat may be accepted in the same cycle the output beat is consumed. Full rate is sustained.
- Critical path: one CHUNK-bit carry chain plus flag logic. No combinational path from A/B to S.
- Combinational paths: in_ready depends combinationally on out_ready (ready passthrough).

## Test plan
- WIDTH=32, STAGES=4: add 0xFFFFFFFF + 0x00000001, cin = 0 → after 4 cycles S = 0x00000000, cout = 1, zero = 1, overflow = 0. The carry crosses all three stage boundaries.
- Signed overflow:
  - Add 0x7FFFFFFF + 1 → S = 0x80000000, overflow = 1, cout = 0.
  - Subtract 0x80000000 − 1 → S = 0x7FFFFFFF, overflow = 1, cout = 1.
- Subtract 5 − 7, cin = 0 → S = 0xFFFFFFFE, cout = 0 (borrow), overflow = 0. Subtract 10 − 3 with cin = 1 → S = 6, cout = 1.
- Streaming: 16 back-to-back random beats, out_ready driven by a random 50% pattern → results match a reference model in order, with none lost or duplicated. Outputs hold stable while out_valid && !out_ready, and in_ready == !out_valid || out_ready every cycle.
- Reset mid-stream: assert rst for 1 cycle with 3 beats in flight → out_valid = 0 and all outputs 0 the next cycle. No stale beat emerges afterwards. A new beat issued afterwards appears after exactly STAGES cycles.
- Parameter sweep: (WIDTH, STAGES) ∈ {(32,1), (32,32), (16,2), (64,8)}, each with 0x00…0FF…F + 1 and random beats → results correct and latency equals STAGES in each configuration.
